// File: rtl/fetch_dma_issuer.sv
// fetch_dma_issuer: pops fetch-queue entries, issues tagged DMA read
// requests (at most 64 bytes each) and turns DMA completions into
// DBUFF_UPDATE notifications for the SRPT data queue.
// Optional build macro: FETCH_DMA_ISSUER_STATS_EN adds request/response
// handshake counters (stat_req_count_o, stat_resp_count_o).
// ap_ce/ap_start are expected to be held steady around a handshake.
module fetch_dma_issuer #(
    parameter int MAX_OUTSTANDING = 8,
    localparam int TW = $clog2(MAX_OUTSTANDING),
    localparam int RW = TW + 9 + 20 + 7
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          ap_ce,
    input  logic          ap_start,
    input  logic          ap_continue,
    output logic          ap_idle,
    output logic          ap_done,
    output logic          ap_ready,
    input  logic          fetch_in_empty_i,
    output logic          fetch_in_read_en_o,
    input  logic [98:0]   fetch_in_data_i,
    output logic          dma_req_valid_o,
    input  logic          dma_req_ready_i,
    output logic [RW-1:0] dma_req_data_o,
    input  logic          dma_resp_valid_i,
    output logic          dma_resp_ready_o,
    input  logic [TW-1:0] dma_resp_tag_i,
    input  logic          dbuff_notif_full_i,
    output logic          dbuff_notif_write_en_o,
    output logic [98:0]   dbuff_notif_data_o
`ifdef FETCH_DMA_ISSUER_STATS_EN
    ,
    output logic [31:0]   stat_req_count_o,
    output logic [31:0]   stat_resp_count_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        req_data_q, req_data_d;
    logic [MAX_OUTSTANDING-1:0] tag_busy_q, tag_busy_d;
    logic [15:0]          tag_rpc_q   [MAX_OUTSTANDING];
    logic [15:0]          tag_rpc_d   [MAX_OUTSTANDING];
    logic [8:0]           tag_dbuff_q [MAX_OUTSTANDING];
    logic [8:0]           tag_dbuff_d [MAX_OUTSTANDING];
    logic [19:0]          tag_off_q   [MAX_OUTSTANDING];
    logic [19:0]          tag_off_d   [MAX_OUTSTANDING];
    logic [6:0]           tag_len_q   [MAX_OUTSTANDING];
    logic [6:0]           tag_len_d   [MAX_OUTSTANDING];
    logic                 notif_valid_q, notif_valid_d;
    logic [98:0]          notif_data_q, notif_data_d;

    logic                 adv_s;
    logic                 free_found_s;
    logic [TW-1:0]        free_tag_s;
    logic                 pop_s;
    logic                 notif_wr_s;
    logic                 resp_ready_s;
    logic                 resp_hs_s;
    logic                 req_valid_s;
    logic                 req_hs_s;
    logic [19:0]          rem_s;
    logic [6:0]           len_s;
    logic [19:0]          done_off_s;
    logic                 unused_s;

    assign ap_idle  = 1'b0;
    assign ap_done  = 1'b1;
    assign ap_ready = 1'b1;

    // Fields of the queue entry that this block never consumes.
    assign unused_s = ^{ap_continue, fetch_in_data_i[98:89], fetch_in_data_i[88:66],
                        fetch_in_data_i[25]};

    // Lowest-index free tag, judged from the registered busy map so a tag
    // freed this cycle only becomes allocatable on the next one.
    always_comb begin
        free_found_s = 1'b0;
        free_tag_s   = {TW{1'b0}};
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!tag_busy_q[i]) begin
                free_found_s = 1'b1;
                free_tag_s   = TW'(i);
            end else begin
                free_found_s = free_found_s;
                free_tag_s   = free_tag_s;
            end
        end
    end

    // Handshake qualifiers, length clamp and completion offset.
    always_comb begin
        adv_s        = ap_ce && ap_start && !ap_rst;
        rem_s        = fetch_in_data_i[45:26];
        len_s        = (rem_s >= 20'd64) ? 7'd64 : rem_s[6:0];
        pop_s        = adv_s && (state_q == ST_IDLE) && fetch_in_empty_i && free_found_s;
        req_valid_s  = adv_s && (state_q == ST_REQ);
        req_hs_s     = req_valid_s && dma_req_ready_i;
        notif_wr_s   = adv_s && notif_valid_q && dbuff_notif_full_i;
        resp_ready_s = adv_s && (!notif_valid_q || notif_wr_s);
        resp_hs_s    = dma_resp_valid_i && resp_ready_s;
        done_off_s   = tag_off_q[dma_resp_tag_i] + {13'd0, tag_len_q[dma_resp_tag_i]};
    end

    assign fetch_in_read_en_o     = pop_s;
    assign dma_req_valid_o        = req_valid_s;
    assign dma_req_data_o         = req_data_q;
    assign dma_resp_ready_o       = resp_ready_s;
    assign dbuff_notif_write_en_o = notif_wr_s;
    assign dbuff_notif_data_o     = notif_data_q;

    // Issue FSM, tag table and notification register next-state logic.
    always_comb begin
        state_d       = state_q;
        req_data_d    = req_data_q;
        tag_busy_d    = tag_busy_q;
        tag_rpc_d     = tag_rpc_q;
        tag_dbuff_d   = tag_dbuff_q;
        tag_off_d     = tag_off_q;
        tag_len_d     = tag_len_q;
        notif_valid_d = notif_valid_q;
        notif_data_d  = notif_data_q;

        // Completion: a live tag yields a notification and is released;
        // a stale tag is swallowed silently.
        if (resp_hs_s && tag_busy_q[dma_resp_tag_i]) begin
            notif_valid_d = 1'b1;
            notif_data_d  = {10'd0, 3'b001, 20'd0, done_off_s, 20'd0, 1'b0,
                             tag_dbuff_q[dma_resp_tag_i], tag_rpc_q[dma_resp_tag_i]};
            tag_busy_d[dma_resp_tag_i] = 1'b0;
        end else if (notif_wr_s) begin
            notif_valid_d = 1'b0;
            notif_data_d  = 99'd0;
        end else begin
            notif_valid_d = notif_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop_s && (rem_s != 20'd0)) begin
                    tag_busy_d[free_tag_s]  = 1'b1;
                    tag_rpc_d[free_tag_s]   = fetch_in_data_i[15:0];
                    tag_dbuff_d[free_tag_s] = fetch_in_data_i[24:16];
                    tag_off_d[free_tag_s]   = fetch_in_data_i[65:46];
                    tag_len_d[free_tag_s]   = len_s;
                    req_data_d = {free_tag_s, fetch_in_data_i[24:16], fetch_in_data_i[65:46], len_s};
                    state_d    = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= ST_IDLE;
            req_data_q    <= {RW{1'b0}};
            tag_busy_q    <= {MAX_OUTSTANDING{1'b0}};
            notif_valid_q <= 1'b0;
            notif_data_q  <= 99'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_rpc_q[i]   <= 16'd0;
                tag_dbuff_q[i] <= 9'd0;
                tag_off_q[i]   <= 20'd0;
                tag_len_q[i]   <= 7'd0;
            end
        end else begin
            state_q       <= state_d;
            req_data_q    <= req_data_d;
            tag_busy_q    <= tag_busy_d;
            notif_valid_q <= notif_valid_d;
            notif_data_q  <= notif_data_d;
            tag_rpc_q     <= tag_rpc_d;
            tag_dbuff_q   <= tag_dbuff_d;
            tag_off_q     <= tag_off_d;
            tag_len_q     <= tag_len_d;
        end
    end

`ifdef FETCH_DMA_ISSUER_STATS_EN
    logic [31:0] stat_req_q, stat_req_d;
    logic [31:0] stat_resp_q, stat_resp_d;

    // Wrapping handshake counters.
    always_comb begin
        stat_req_d  = req_hs_s  ? (stat_req_q + 32'd1)  : stat_req_q;
        stat_resp_d = resp_hs_s ? (stat_resp_q + 32'd1) : stat_resp_q;
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stat_req_q  <= 32'd0;
            stat_resp_q <= 32'd0;
        end else begin
            stat_req_q  <= stat_req_d;
            stat_resp_q <= stat_resp_d;
        end
    end

    assign stat_req_count_o  = stat_req_q;
    assign stat_resp_count_o = stat_resp_q;
`endif

endmodule

// File: tb/tb_fetch_dma_issuer.sv
// Directed self-checking bench for fetch_dma_issuer (default build).
module tb_fetch_dma_issuer;

    localparam int TW = 3;
    localparam int RW = TW + 36;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_ce;
    logic          ap_start;
    logic          ap_continue;
    logic          ap_idle;
    logic          ap_done;
    logic          ap_ready;
    logic          fetch_in_empty_i;
    logic          fetch_in_read_en_o;
    logic [98:0]   fetch_in_data_i;
    logic          dma_req_valid_o;
    logic          dma_req_ready_i;
    logic [RW-1:0] dma_req_data_o;
    logic          dma_resp_valid_i;
    logic          dma_resp_ready_o;
    logic [TW-1:0] dma_resp_tag_i;
    logic          dbuff_notif_full_i;
    logic          dbuff_notif_write_en_o;
    logic [98:0]   dbuff_notif_data_o;

    int n_total = 0;
    int n_bad   = 0;

    fetch_dma_issuer #(.MAX_OUTSTANDING(8)) dut (
        .ap_clk                 (ap_clk),
        .ap_rst                 (ap_rst),
        .ap_ce                  (ap_ce),
        .ap_start               (ap_start),
        .ap_continue            (ap_continue),
        .ap_idle                (ap_idle),
        .ap_done                (ap_done),
        .ap_ready               (ap_ready),
        .fetch_in_empty_i       (fetch_in_empty_i),
        .fetch_in_read_en_o     (fetch_in_read_en_o),
        .fetch_in_data_i        (fetch_in_data_i),
        .dma_req_valid_o        (dma_req_valid_o),
        .dma_req_ready_i        (dma_req_ready_i),
        .dma_req_data_o         (dma_req_data_o),
        .dma_resp_valid_i       (dma_resp_valid_i),
        .dma_resp_ready_o       (dma_resp_ready_o),
        .dma_resp_tag_i         (dma_resp_tag_i),
        .dbuff_notif_full_i     (dbuff_notif_full_i),
        .dbuff_notif_write_en_o (dbuff_notif_write_en_o),
        .dbuff_notif_data_o     (dbuff_notif_data_o)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic clk_step();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [98:0] entry(input int rpc, input int dbuff, input int rem,
                                          input int dbuffered, input logic [2:0] prio);
        logic [98:0] e;
        e = 99'd0;
        e[15:0]  = rpc[15:0];
        e[24:16] = dbuff[8:0];
        e[45:26] = rem[19:0];
        e[65:46] = dbuffered[19:0];
        e[85:66] = 20'd7;
        e[88:86] = prio;
        return e;
    endfunction

    function automatic logic [RW-1:0] req_word(input int tag, input int dbuff, input int off, input int len);
        return {tag[2:0], dbuff[8:0], off[19:0], len[6:0]};
    endfunction

    function automatic logic [98:0] notif_word(input int rpc, input int dbuff, input int dbuffered);
        logic [98:0] n;
        n = 99'd0;
        n[15:0]  = rpc[15:0];
        n[24:16] = dbuff[8:0];
        n[65:46] = dbuffered[19:0];
        n[88:86] = 3'b001;
        return n;
    endfunction

    initial begin
        ap_rst = 1'b1; ap_ce = 1'b1; ap_start = 1'b1; ap_continue = 1'b0;
        fetch_in_empty_i = 1'b1; fetch_in_data_i = entry(9, 9, 100, 0, 3'b101);
        dma_req_ready_i = 1'b0; dma_resp_valid_i = 1'b0; dma_resp_tag_i = 3'd0;
        dbuff_notif_full_i = 1'b1;

        // Reset state
        clk_step();
        clk_step();
        #1;
        chk("rst_read_en", fetch_in_read_en_o, 1'b0);
        chk("rst_req_valid", dma_req_valid_o, 1'b0);
        chk("rst_req_data", dma_req_data_o, 0);
        chk("rst_notif_we", dbuff_notif_write_en_o, 1'b0);
        chk("rst_notif_data", dbuff_notif_data_o, 0);
        chk("ap_idle", ap_idle, 1'b0);
        chk("ap_done", ap_done, 1'b1);
        chk("ap_ready", ap_ready, 1'b1);
        fetch_in_empty_i = 1'b0;
        ap_rst = 1'b0;

        // Basic request: RPC 1, DBUFF 1, REMAINING 1000 -> len 64
        clk_step();
        fetch_in_data_i = entry(1, 1, 1000, 0, 3'b101);
        fetch_in_empty_i = 1'b1; dma_req_ready_i = 1'b1;
        #1;
        chk("pop1_read_en", fetch_in_read_en_o, 1'b1);
        chk("pop1_no_valid_yet", dma_req_valid_o, 1'b0);
        clk_step();
        fetch_in_empty_i = 1'b0;
        #1;
        chk("req1_valid", dma_req_valid_o, 1'b1);
        chk("req1_data", dma_req_data_o, req_word(0, 1, 0, 64));
        chk("req1_no_pop_in_req", fetch_in_read_en_o, 1'b0);
        clk_step();
        #1;
        chk("req1_valid_drop", dma_req_valid_o, 1'b0);

        // Completion tag 0 -> notification RPC 1 DBUFFERED 64
        dma_resp_valid_i = 1'b1; dma_resp_tag_i = 3'd0; dbuff_notif_full_i = 1'b1;
        #1;
        chk("resp1_ready", dma_resp_ready_o, 1'b1);
        clk_step();
        dma_resp_valid_i = 1'b0;
        #1;
        chk("notif1_we", dbuff_notif_write_en_o, 1'b1);
        chk("notif1_data", dbuff_notif_data_o, notif_word(1, 1, 64));
        clk_step();
        #1;
        chk("notif1_we_clear", dbuff_notif_write_en_o, 1'b0);

        // Short tail: REMAINING 40, DBUFFERED 960 -> len 40, completion at 1000
        fetch_in_data_i = entry(2, 5, 40, 960, 3'b010);
        fetch_in_empty_i = 1'b1;
        #1;
        chk("pop2_read_en", fetch_in_read_en_o, 1'b1);
        clk_step();
        fetch_in_empty_i = 1'b0;
        #1;
        chk("req2_data", dma_req_data_o, req_word(0, 5, 960, 40));
        clk_step();
        dma_resp_valid_i = 1'b1; dma_resp_tag_i = 3'd0;
        #1;
        clk_step();
        dma_resp_valid_i = 1'b0;
        #1;
        chk("notif2_data", dbuff_notif_data_o, notif_word(2, 5, 1000));
        clk_step();

        // REMAINING 0: popped and discarded, no request
        fetch_in_data_i = entry(7, 7, 0, 0, 3'b101);
        fetch_in_empty_i = 1'b1;
        #1;
        chk("zero_read_en", fetch_in_read_en_o, 1'b1);
        clk_step();
        fetch_in_empty_i = 1'b0;
        #1;
        chk("zero_no_req", dma_req_valid_o, 1'b0);

        // Eight requests take tags 0..7 (zero entry consumed none)
        for (int i = 0; i < 8; i++) begin
            clk_step();
            fetch_in_data_i = entry(10 + i, 10 + i, 100, 0, 3'b101);
            fetch_in_empty_i = 1'b1;
            #1;
            chk("fill_read_en", fetch_in_read_en_o, 1'b1);
            clk_step();
            fetch_in_empty_i = 1'b0;
            #1;
            chk("fill_req_data", dma_req_data_o, req_word(i, 10 + i, 0, 64));
        end
        clk_step();
        fetch_in_data_i = entry(20, 20, 100, 0, 3'b101);
        fetch_in_empty_i = 1'b1;
        #1;
        chk("ninth_blocked_a", fetch_in_read_en_o, 1'b0);
        clk_step();
        #1;
        chk("ninth_blocked_b", fetch_in_read_en_o, 1'b0);
        dma_resp_valid_i = 1'b1; dma_resp_tag_i = 3'd3;
        #1;
        chk("ninth_no_same_cycle_reuse", fetch_in_read_en_o, 1'b0);
        clk_step();
        dma_resp_valid_i = 1'b0;
        #1;
        chk("ninth_read_en", fetch_in_read_en_o, 1'b1);
        chk("tag3_notif_we", dbuff_notif_write_en_o, 1'b1);
        chk("tag3_notif_data", dbuff_notif_data_o, notif_word(13, 13, 64));
        clk_step();
        fetch_in_empty_i = 1'b0;
        #1;
        chk("ninth_req_tag3", dma_req_data_o, req_word(3, 20, 0, 64));
        chk("tag3_notif_drained", dbuff_notif_write_en_o, 1'b0);
        clk_step();

        // Back-pressure: tag 2 then tag 0 while sink is full
        dbuff_notif_full_i = 1'b0;
        dma_resp_valid_i = 1'b1; dma_resp_tag_i = 3'd2;
        #1;
        chk("bp_first_ready", dma_resp_ready_o, 1'b1);
        clk_step();
        dma_resp_tag_i = 3'd0;
        #1;
        chk("bp_second_ready_low", dma_resp_ready_o, 1'b0);
        chk("bp_no_write", dbuff_notif_write_en_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clk_step();
            #1;
            chk("bp_hold_ready_low", dma_resp_ready_o, 1'b0);
        end
        clk_step();
        dbuff_notif_full_i = 1'b1;
        #1;
        chk("bp_notif_a_we", dbuff_notif_write_en_o, 1'b1);
        chk("bp_notif_a_tag2", dbuff_notif_data_o, notif_word(12, 12, 64));
        chk("bp_ready_on_drain", dma_resp_ready_o, 1'b1);
        clk_step();
        dma_resp_valid_i = 1'b0;
        #1;
        chk("bp_notif_b_we", dbuff_notif_write_en_o, 1'b1);
        chk("bp_notif_b_tag0", dbuff_notif_data_o, notif_word(10, 10, 64));
        clk_step();
        #1;
        chk("bp_done_we", dbuff_notif_write_en_o, 1'b0);

        // Reset mid-transaction with 3 tags out
        ap_rst = 1'b1;
        clk_step();
        ap_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            fetch_in_data_i = entry(30 + i, 30 + i, 64, 0, 3'b101);
            fetch_in_empty_i = 1'b1;
            dma_req_ready_i = 1'b1;
            #1;
            clk_step();
            fetch_in_empty_i = 1'b0;
            #1;
            chk("rst_fill_req", dma_req_data_o, req_word(i, 30 + i, 0, 64));
        end
        clk_step();
        fetch_in_data_i = entry(40, 40, 64, 0, 3'b101);
        fetch_in_empty_i = 1'b1;
        dma_req_ready_i = 1'b0;
        #1;
        clk_step();
        fetch_in_empty_i = 1'b0;
        #1;
        chk("stall_valid", dma_req_valid_o, 1'b1);
        clk_step();
        #1;
        chk("stall_valid_held", dma_req_valid_o, 1'b1);
        chk("stall_data_held", dma_req_data_o, req_word(3, 40, 0, 64));
        ap_rst = 1'b1;
        #1;
        chk("rst_valid_drops", dma_req_valid_o, 1'b0);
        clk_step();
        ap_rst = 1'b0;
        #1;
        chk("post_rst_valid", dma_req_valid_o, 1'b0);
        chk("post_rst_data", dma_req_data_o, 0);
        dma_resp_valid_i = 1'b1; dma_resp_tag_i = 3'd1; dbuff_notif_full_i = 1'b1;
        #1;
        chk("stale_resp_ready", dma_resp_ready_o, 1'b1);
        clk_step();
        dma_resp_valid_i = 1'b0;
        #1;
        chk("stale_no_notif", dbuff_notif_write_en_o, 1'b0);
        chk("stale_notif_data", dbuff_notif_data_o, 0);
        fetch_in_data_i = entry(50, 50, 64, 0, 3'b101);
        fetch_in_empty_i = 1'b1;
        dma_req_ready_i = 1'b1;
        #1;
        chk("post_rst_pop", fetch_in_read_en_o, 1'b1);
        clk_step();
        fetch_in_empty_i = 1'b0;
        #1;
        chk("post_rst_tag0", dma_req_data_o, req_word(0, 50, 0, 64));
        clk_step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_dma_issuer.md
FETCH_DMA_ISSUER -- requirements
Module: fetch_dma_issuer

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 8, SHALL set the number of in-flight DMA read tags (power of 2, tag width TW = log2).
REQ-002 ap_clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 ap_rst  in  1  reset, synchronous and active-high.
REQ-004 ap_ce, ap_start, ap_continue  in  1 each  state SHALL advance only when ap_ce && ap_start; ap_continue unused.
REQ-005 fetch_in_empty_i  in  1  high = fetch-queue entry available (producer convention).
REQ-006 fetch_in_read_en_o  out  1  pops one 99-bit entry.
REQ-007 fetch_in_data_i  in  99  queue entry: RPC_ID[15:0], DBUFF_ID[24:16], REMAINING[45:26], DBUFFERED[65:46], GRANTED[85:66], PRIORITY[88:86].
REQ-008 dma_req_valid_o / dma_req_ready_i  out/in  1  valid-ready DMA read request.
REQ-009 dma_req_data_o  out  TW+9+20+7  {tag, dbuff_id, byte offset, length}.
REQ-010 dma_resp_valid_i / dma_resp_ready_o  in/out  1  valid-ready completion, dma_resp_tag_i  in  TW.
REQ-011 dbuff_notif_full_i  in  1  high = notification sink has space.
REQ-012 dbuff_notif_write_en_o  out  1, dbuff_notif_data_o  out  99  DBUFF_UPDATE entry to the SRPT data queue.
REQ-013 ap_idle, ap_done, ap_ready  out  1  SHALL be constant 0, 1, 1.

Function
REQ-014 Issue FSM SHALL have states IDLE and REQ.
REQ-015 In IDLE, fetch_in_read_en_o SHALL assert combinationally iff fetch_in_empty_i, PRIORITY == 3'b101 (ACTIVE) or any value, and a free tag exists; entry is latched and state goes to REQ next cycle.
REQ-016 On pop the lowest-index free tag SHALL be allocated and its table slot loaded with rpc_id, dbuff_id, offset = DBUFFERED, length = min(REMAINING, 64).
REQ-017 In REQ, dma_req_valid_o SHALL be 1 with registered data held stable until dma_req_ready_i; on handshake FSM returns to IDLE (next pop no earlier than following cycle).
REQ-018 Pop-to-request latency SHALL be exactly 1 cycle; one request per 2 cycles maximum.
REQ-019 REMAINING == 0 entries SHALL be popped and discarded, no tag allocated, no request.
REQ-020 dma_resp_ready_o SHALL be 1 when the notification register is empty or being drained this cycle.
REQ-021 On response handshake, notification register SHALL load: RPC_ID, DBUFF_ID from tag slot, DBUFFERED = offset + length (20-bit), PRIORITY = 3'b001, all other fields 0; tag freed same edge.
REQ-022 dbuff_notif_write_en_o SHALL pulse 1 cycle when register valid and dbuff_notif_full_i high; register then clears.
REQ-023 Response with tag not currently allocated SHALL be accepted and dropped, no notification.
REQ-024 Allocation and free in the same cycle SHALL both take effect; a tag freed this cycle SHALL NOT be reallocated until next cycle.
REQ-025 Completions MAY return out of order; notifications SHALL follow completion order.

Reset
REQ-026 ap_rst SHALL clear FSM to IDLE, free all tags, clear notification register; dma_req_valid_o, dbuff_notif_write_en_o, fetch_in_read_en_o, dma_req_data_o, dbuff_notif_data_o = 0.
REQ-027 Reset mid-transaction SHALL discard in-flight tags; later responses with those tags are dropped per REQ-023.

Configuration
REQ-028 Macro FETCH_DMA_ISSUER_STATS_EN defined: outputs stat_req_count_o and stat_resp_count_o (32-bit, wrap, reset 0) SHALL count request and valid-response handshakes; undefined: ports and counters absent, behaviour otherwise identical.

Verification
REQ-029 Entry RPC 1, DBUFF 1, REMAINING 1000, DBUFFERED 0, ready high -> request {tag 0, dbuff 1, off 0, len 64} 1 cycle after pop.
REQ-030 Response tag 0 with sink space -> notification RPC 1, DBUFFERED 64, PRIORITY 1 next cycle.
REQ-031 Nine entries, no responses -> 8 requests tags 0-7, ninth not popped; response tag 3 -> ninth popped, gets tag 3.
REQ-032 REMAINING 40, DBUFFERED 960 -> len 40; completion -> DBUFFERED 1000.
REQ-033 Responses tags 2 then 0 with sink full for 5 cycles -> dma_resp_ready_o low after first, notifications tag 2 then tag 0 once full releases.
REQ-034 ap_rst during REQ with 3 tags out -> valid drops; stale response tag 1 produces no notification.
